// File: rtl/wb_pipe.sv
// wb_pipe: parametrised EX -> regfile result pipeline.
// DEPTH stages with per-stage stall, global flush, late load-data fill at
// LATE_STAGE, and NUM_RD forwarding/busy lookup ports for decode.

// One pipeline stage: holds an entry, takes a bubble, or loads from upstream.
module wb_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit FILL     = 1'b0,  // this stage captures late load data
  parameter bit CHK_LATE = 1'b0   // late entries are illegal here
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              in_v,
  input  logic              in_wreg,
  input  logic              in_late,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] fill_data,
  output logic              v,
  output logic              wreg,
  output logic              late,
  output logic [ADDR_W-1:0] wd,
  output logic [DATA_W-1:0] wdata
);
  // Reset and flush clear the entry; hold keeps it (no refill while held).
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      v <= 1'b0; wreg <= 1'b0; late <= 1'b0; wd <= '0; wdata <= '0;
    end else if (!hold) begin
      if (bubble) begin
        v <= 1'b0; wreg <= 1'b0; late <= 1'b0; wd <= '0; wdata <= '0;
      end else begin
        v    <= in_v;
        wreg <= in_wreg;
        wd   <= in_wd;
        if (FILL && in_late) begin
          wdata <= fill_data;
          late  <= 1'b0;
        end else begin
          wdata <= in_wdata;
          late  <= in_late;
        end
      end
    end
  end

  // Any late entry must have been filled before reaching this stage.
  always_ff @(posedge clk) begin
    if (CHK_LATE && rst) assert (!(v && late));
  end
endmodule

// One forwarding lookup port over NCAND candidates, index 0 youngest.
module wb_fwd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NCAND  = 4
) (
  input  logic [NCAND-1:0]             cand_v,
  input  logic [NCAND-1:0]             cand_wreg,
  input  logic [NCAND-1:0]             cand_late,
  input  logic [NCAND-1:0][ADDR_W-1:0] cand_wd,
  input  logic [NCAND-1:0][DATA_W-1:0] cand_data,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         re,
  output logic                         hit,
  output logic                         busy,
  output logic [DATA_W-1:0]            data
);
  logic              found;
  logic              sel_late;
  logic [DATA_W-1:0] sel_data;

  // Scan oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    found    = 1'b0;
    sel_late = 1'b0;
    sel_data = '0;
    for (int i = NCAND-1; i >= 0; i--) begin
      if (cand_v[i] && cand_wreg[i] && (cand_wd[i] == addr)) begin
        found    = 1'b1;
        sel_late = cand_late[i];
        sel_data = cand_data[i];
      end
    end
  end

  // r0 never forwards; a late winner means the value is not here yet.
  always_comb begin
    hit  = 1'b0;
    busy = 1'b0;
    data = '0;
    if (re && (addr != '0) && found) begin
      if (sel_late) begin
        busy = 1'b1;
      end else begin
        hit  = 1'b1;
        data = sel_data;
      end
    end
  end
endmodule

module wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,   // >= 2
  parameter int NUM_RD     = 2,
  parameter int LATE_STAGE = 1    // 1 .. DEPTH-1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_wreg,
  input  logic [ADDR_W-1:0]        in_wd,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic                     in_late,
  output logic                     in_accept,
  input  logic [DATA_W-1:0]        mem_data_i,
  input  logic [DEPTH-1:0]         stall_i,
  input  logic                     flush_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_re,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD-1:0]        fwd_busy,
  output logic                     wb_we,
  output logic [ADDR_W-1:0]        wb_waddr,
  output logic [DATA_W-1:0]        wb_wdata
);
  localparam int TOP = DEPTH - 1;

  // Stage state, index 0 youngest.
  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0]             wreg_q;
  logic [DEPTH-1:0]             late_q;
  logic [DEPTH-1:0][ADDR_W-1:0] wd_q;
  logic [DEPTH-1:0][DATA_W-1:0] wdata_q;

  // Upstream source of each stage: EX input for stage 0, else stage k-1.
  logic [DEPTH-1:0]             src_v;
  logic [DEPTH-1:0]             src_wreg;
  logic [DEPTH-1:0]             src_late;
  logic [DEPTH-1:0][ADDR_W-1:0] src_wd;
  logic [DEPTH-1:0][DATA_W-1:0] src_wdata;
  logic [DEPTH-1:0]             bubble;

  assign src_v     = {vld_pipe[DEPTH-2:0], in_valid};
  assign src_wreg  = {wreg_q[DEPTH-2:0],   in_valid & in_wreg};
  assign src_late  = {late_q[DEPTH-2:0],   in_valid & in_late};
  assign src_wd    = {wd_q[DEPTH-2:0],     in_wd};
  assign src_wdata = {wdata_q[DEPTH-2:0],  in_wdata};
  // A stalled upstream stage leaves a hole in the next one down.
  assign bubble    = {stall_i[DEPTH-2:0],  1'b0};

  assign in_accept = in_valid & ~stall_i[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    wb_stage #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .FILL    (k == LATE_STAGE),
      .CHK_LATE(k >= LATE_STAGE)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_i),
      .hold     (stall_i[k]),
      .bubble   (bubble[k]),
      .in_v     (src_v[k]),
      .in_wreg  (src_wreg[k]),
      .in_late  (src_late[k]),
      .in_wd    (src_wd[k]),
      .in_wdata (src_wdata[k]),
      .fill_data(mem_data_i),
      .v        (vld_pipe[k]),
      .wreg     (wreg_q[k]),
      .late     (late_q[k]),
      .wd       (wd_q[k]),
      .wdata    (wdata_q[k])
    );
  end

  // Writeback: a held entry writes once, in the cycle its stall drops.
  assign wb_we    = vld_pipe[TOP] & wreg_q[TOP] & ~stall_i[TOP] & (wd_q[TOP] != '0);
  assign wb_waddr = wb_we ? wd_q[TOP]    : '0;
  assign wb_wdata = wb_we ? wdata_q[TOP] : '0;

  // Forwarding candidates: 0 is the EX input (dropped on flush), k+1 is stage k.
  logic [DEPTH:0]             cand_v;
  logic [DEPTH:0]             cand_wreg;
  logic [DEPTH:0]             cand_late;
  logic [DEPTH:0][ADDR_W-1:0] cand_wd;
  logic [DEPTH:0][DATA_W-1:0] cand_data;

  assign cand_v    = {vld_pipe, in_valid & ~flush_i};
  assign cand_wreg = {wreg_q,   in_wreg};
  assign cand_late = {late_q,   in_late};
  assign cand_wd   = {wd_q,     in_wd};
  assign cand_data = {wdata_q,  in_wdata};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    wb_fwd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NCAND (DEPTH + 1)
    ) u_fwd (
      .cand_v   (cand_v),
      .cand_wreg(cand_wreg),
      .cand_late(cand_late),
      .cand_wd  (cand_wd),
      .cand_data(cand_data),
      .addr     (rd_addr[p*ADDR_W +: ADDR_W]),
      .re       (rd_re[p]),
      .hit      (fwd_hit[p]),
      .busy     (fwd_busy[p]),
      .data     (fwd_data[p*DATA_W +: DATA_W])
    );
  end
endmodule
